// File: rtl/fb_arb_pkg.sv
// Shared types for the frame-buffer memory arbiter: FSM state encoding,
// default bus widths and the state-update helper.
package fb_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAW  = 2'd2
  } fb_arb_state_e;

  // The state only remembers who won the last cycle.
  function automatic fb_arb_state_e arb_next_state(input logic fetch_xfer,
                                                   input logic draw_xfer);
    if (fetch_xfer) return FETCH;
    if (draw_xfer) return DRAW;
    return IDLE;
  endfunction

endpackage

// File: rtl/fb_arb_starve_ctr.sv
// Counts fetch transfers that happen while draw waits; starve flags when
// draw must be forced through. Saturates at STARVE_MAX.
module fb_arb_starve_ctr #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic draw_rts,
  input  logic fetch_xfer,
  input  logic draw_xfer,
  output logic starve
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (draw_xfer || !draw_rts) begin
      cnt <= '0;
    end else if (fetch_xfer && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign starve = (cnt == CNT_MAX);

endmodule

// File: rtl/fb_mem_arbiter.sv
// Two-requester frame-buffer RAM arbiter: display fetch (read-only) has
// priority over draw; FB_ARB_STARVE_GUARD_EN adds a draw starvation guard.
module fb_mem_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_rts,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rtr,
  output logic              fetch_rd_valid,
  output logic [DATA_W-1:0] fetch_rd_data,
  input  logic              draw_rts,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_rtr,
  output logic              draw_rd_valid,
  output logic [DATA_W-1:0] draw_rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  fb_arb_state_e state;
  logic          fetch_gnt;
  logic          draw_gnt;
  logic          starve;
  logic          draw_rd_p1;
  logic          fetch_vld_p1;
  logic          draw_vld_p1;

`ifdef FB_ARB_STARVE_GUARD_EN
  fb_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk        (clk),
    .rst        (rst),
    .draw_rts   (draw_rts),
    .fetch_xfer (fetch_gnt),
    .draw_xfer  (draw_gnt),
    .starve     (starve)
  );
`else
  assign starve = 1'b0;
`endif

  // Grants are gated by rst so the memory port goes quiet the moment reset hits.
  always_comb begin
    fetch_gnt = 1'b0;
    draw_gnt  = 1'b0;
    if (!rst) begin
      if (draw_rts && starve) begin
        draw_gnt = 1'b1;
      end else if (fetch_rts) begin
        fetch_gnt = 1'b1;
      end else if (draw_rts) begin
        draw_gnt = 1'b1;
      end
    end
  end

  assign fetch_rtr = fetch_gnt;
  assign draw_rtr  = draw_gnt;

  // Stage p0: memory command in the transfer cycle
  assign mem_en    = fetch_gnt | draw_gnt;
  assign mem_we    = draw_gnt & draw_we;
  assign mem_addr  = fetch_gnt ? fetch_addr : (draw_gnt ? draw_addr : '0);
  assign mem_wdata = (draw_gnt && draw_we) ? draw_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      draw_rd_p1 <= 1'b0;
    end else begin
      state      <= arb_next_state(fetch_gnt, draw_gnt);
      draw_rd_p1 <= draw_gnt & ~draw_we;
    end
  end

  // Stage p1: read return; fetch is always a read, so FETCH state implies data
  assign fetch_vld_p1   = (state == FETCH);
  assign draw_vld_p1    = (state == DRAW) && draw_rd_p1;

  assign fetch_rd_valid = fetch_vld_p1;
  assign draw_rd_valid  = draw_vld_p1;
  assign fetch_rd_data  = fetch_vld_p1 ? mem_rdata : '0;
  assign draw_rd_data   = draw_vld_p1 ? mem_rdata : '0;

endmodule

// File: doc/fb_mem_arbiter.md
FB_MEM_ARBITER -- requirements
Module: fb_mem_arbiter

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- ADDR_W, 16, frame-buffer word address width.
- DATA_W, 32, frame-buffer word width (packed pixels).
- STARVE_MAX, 8, consecutive fetch transfers tolerated while draw waits.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- fetch_rts, in, 1, display fetch engine read request.
- fetch_addr, in, ADDR_W, fetch read address.
- fetch_rtr, out, 1, fetch request accepted this cycle.
- fetch_rd_valid, out, 1, fetch read data valid.
- fetch_rd_data, out, DATA_W, fetch read data.
- draw_rts, in, 1, draw engine request.
- draw_we, in, 1, draw request is a write (1) or read (0).
- draw_addr, in, ADDR_W, draw address.
- draw_wdata, in, DATA_W, draw write data.
- draw_rtr, out, 1, draw request accepted this cycle.
- draw_rd_valid, out, 1, draw read data valid.
- draw_rd_data, out, DATA_W, draw read data.
- mem_en, out, 1, RAM access strobe.
- mem_we, out, 1, RAM write enable.
- mem_addr, out, ADDR_W, RAM address.
- mem_wdata, out, DATA_W, RAM write data.
- mem_rdata, in, DATA_W, RAM read data, valid one cycle after a read strobe.

Function
REQ-003 A transfer SHALL occur on any cycle where a requester's rts and rtr are both high; at most one transfer per cycle.
REQ-004 fetch_rtr and draw_rtr SHALL never be high in the same cycle, and rtr SHALL never be high without the matching rts.
REQ-005 mem_en/mem_we/mem_addr/mem_wdata SHALL be driven combinationally from the granted request in the transfer cycle.
- mem_en=0 when no transfer occurs.
- mem_we=0 for fetch transfers.
REQ-006 The FSM SHALL have states IDLE, FETCH, DRAW; its state reflects the last granted requester (IDLE if none).
REQ-007 Default priority SHALL be fetch over draw: when both rts are high, fetch is granted, except per REQ-010.
REQ-008 From any state, the FSM SHALL transition to FETCH on a fetch transfer, to DRAW on a draw transfer, and to IDLE on a cycle with no transfer.
REQ-009 Read latency SHALL be exactly 1 cycle: *_rd_valid is registered high the cycle after that requester's read transfer, with *_rd_data equal to mem_rdata. rd_valid is never asserted for writes.
REQ-010 A starvation counter SHALL:
- increment on each fetch transfer while draw_rts=1;
- clear on any draw transfer, or on any cycle with draw_rts=0.
REQ-011 When the counter equals STARVE_MAX and draw_rts=1, draw SHALL be granted that cycle regardless of fetch_rts; the counter then clears.
REQ-012 The counter SHALL saturate at STARVE_MAX and never wrap.
REQ-013 A requester dropping rts SHALL take effect the same cycle, with no grant and no memory access.

Reset
REQ-014 While rst=1, the following SHALL be held:
- state=IDLE, counter=0;
- all rtr, rd_valid and mem_en/mem_we at 0;
- rd_data and mem_addr/mem_wdata at 0.
REQ-015 A read in flight when rst asserts SHALL produce no rd_valid after reset release.

Configuration
REQ-016 Macro FB_ARB_STARVE_GUARD_EN SHALL control the starvation guard:
- defined: REQ-010 to REQ-012 apply;
- undefined: the counter is absent and fetch has strict priority.

Structure
REQ-017 Package fb_arb_pkg SHALL hold the state enum (IDLE/FETCH/DRAW) and the default ADDR_W/DATA_W constants.
REQ-018 The starvation counter SHALL be sub-module fb_arb_starve_ctr, instantiated only under FB_ARB_STARVE_GUARD_EN.

Verification
REQ-019 Bench SHALL cover:
- Fetch only: read at 0x0010 with mem_rdata=0xA5A5A5A5 -> fetch_rtr=1 at cycle N; fetch_rd_valid=1 and data 0xA5A5A5A5 at N+1.
- Draw write: 0x0200 with data 0x12345678 -> mem_we=1, mem_addr=0x0200 in the same cycle; draw_rd_valid stays 0.
- Both requesting, guard undefined, for 20 cycles -> 20 fetch grants and 0 draw grants.
- Both requesting, guard defined, STARVE_MAX=8 -> 8 fetch grants, then 1 draw grant on the 9th cycle, repeating.
- rst asserted the cycle after a fetch read transfer -> fetch_rd_valid stays 0; all outputs 0 within the same cycle.
